// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and timer register map.
// Imported by the timer front end and its counter core.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [11:0] TMR_CTRL     = 12'h000;
  localparam logic [11:0] TMR_STATUS   = 12'h004;
  localparam logic [11:0] TMR_COUNT    = 12'h008;
  localparam logic [11:0] TMR_COMPARE  = 12'h00C;
  localparam logic [11:0] TMR_PRESCALE = 12'h010;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_COUNT,
    SEL_COMPARE,
    SEL_PRESCALE
  } reg_sel_e;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] cur,
    input logic [31:0] wdata,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaler, 32-bit COUNT, compare and sticky match flag.
// Register writes arrive as enables from the AXI front end.
module timer_core
  import axi_lite_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        auto_reload,
  input  logic [15:0] prescale,
  input  logic        prescale_we,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic [3:0]  count_wstrb,
  input  logic [31:0] compare,
  input  logic        status_clr,
  output logic [31:0] count,
  output logic        match
);

  logic [15:0] presc_q;
  logic        tick;
  logic        eq;
  logic        hit;

  assign tick = en & (presc_q == prescale);
  assign eq   = (count == compare);
  // A software COUNT write swallows the tick, including its match
  assign hit  = tick & ~count_we & eq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (prescale_we) begin
      presc_q <= '0;
    end else if (en) begin
      presc_q <= tick ? '0 : presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count_we) begin
      count <= strb_merge(count, count_wdata, count_wstrb);
    end else if (tick) begin
      count <= (eq & auto_reload) ? '0 : count + 32'd1;
    end
  end

  // New match has priority over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else begin
      match <= hit | (match & ~status_clr);
    end
  end

endmodule

// File: rtl/axi_lite_timer.sv
// AXI4-Lite responder for the prescaled timer/compare block.
// Holds CTRL, COMPARE, PRESCALE and the AW/W/B and AR/R channels.
module axi_lite_timer
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              irq
);

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-3:0] aw_idx_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [ADDR_W-3:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  reg_sel_e          wr_sel;
  reg_sel_e          rd_sel;
  logic [31:0]       rd_word;

  logic [2:0]        ctrl_q;
  logic [31:0]       compare_q;
  logic [15:0]       prescale_q;
  logic [31:0]       count;
  logic              match;

  logic [3:0]        unused_addr;
  assign unused_addr = {s_awaddr[1:0], s_araddr[1:0]};

  function automatic reg_sel_e decode(
    input logic [ADDR_W-3:0] idx
  );
    logic [ADDR_W-1:0] a;
    a = {idx, 2'b00};
    unique case (1'b1)
      a == ADDR_W'(TMR_CTRL):     decode = SEL_CTRL;
      a == ADDR_W'(TMR_STATUS):   decode = SEL_STATUS;
      a == ADDR_W'(TMR_COUNT):    decode = SEL_COUNT;
      a == ADDR_W'(TMR_COMPARE):  decode = SEL_COMPARE;
      a == ADDR_W'(TMR_PRESCALE): decode = SEL_PRESCALE;
      default:                    decode = SEL_NONE;
    endcase
  endfunction

  assign s_awready = ~aw_held & ~s_bvalid;
  assign s_wready  = ~w_held & ~s_bvalid;
  assign s_arready = ~s_rvalid;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign ar_hs  = s_arvalid & s_arready;
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);

  // Live channel values bypass the holding regs on the completing edge
  assign wr_idx  = aw_held ? aw_idx_q : s_awaddr[ADDR_W-1:2];
  assign wr_data = w_held ? w_data_q : s_wdata;
  assign wr_strb = w_held ? w_strb_q : s_wstrb;

  assign wr_sel = decode(wr_idx);
  assign rd_sel = decode(s_araddr[ADDR_W-1:2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_idx_q <= s_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      aw_held <= ~commit & (aw_held | aw_hs);
      w_held  <= ~commit & (w_held | w_hs);
      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      compare_q  <= '0;
      prescale_q <= '0;
    end else if (commit) begin
      case (wr_sel)
        SEL_CTRL: begin
          if (wr_strb[0]) ctrl_q <= wr_data[2:0];
        end
        SEL_COMPARE: begin
          compare_q <= strb_merge(compare_q, wr_data, wr_strb);
        end
        SEL_PRESCALE: begin
          if (wr_strb[0]) prescale_q[7:0]  <= wr_data[7:0];
          if (wr_strb[1]) prescale_q[15:8] <= wr_data[15:8];
        end
        default: ;
      endcase
    end
  end

  timer_core u_core (
    .clk         (clk),
    .reset       (reset),
    .en          (ctrl_q[CTRL_EN]),
    .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
    .prescale    (prescale_q),
    .prescale_we (commit & (wr_sel == SEL_PRESCALE)),
    .count_we    (commit & (wr_sel == SEL_COUNT)),
    .count_wdata (wr_data),
    .count_wstrb (wr_strb),
    .compare     (compare_q),
    .status_clr  (commit & (wr_sel == SEL_STATUS) & wr_strb[0] & wr_data[0]),
    .count       (count),
    .match       (match)
  );

  assign irq = match & ctrl_q[CTRL_IRQ_EN];

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      SEL_CTRL:     rd_word[2:0]  = ctrl_q;
      SEL_STATUS:   rd_word[0]    = match;
      SEL_COUNT:    rd_word       = count;
      SEL_COMPARE:  rd_word       = compare_q;
      SEL_PRESCALE: rd_word[15:0] = prescale_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_word;
      s_rresp  <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_timer.sv
// Directed and randomized bench for axi_lite_timer against a
// cycle-indexed behavioural model of the timer register file.
module tb_axi_lite_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  axi_lite_timer #(.ADDR_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Model: state as seen just after edge m_time
  logic [2:0]  m_ctrl;
  logic        m_match;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic [15:0] m_pre;
  int          m_ph;
  int          m_time;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] c,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit off_ok(input logic [11:0] a);
    return a[11:2] <= 10'd4;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    case (a[11:2])
      10'd0:   return {29'b0, m_ctrl};
      10'd1:   return {31'b0, m_match};
      10'd2:   return m_count;
      10'd3:   return m_cmp;
      10'd4:   return {16'b0, m_pre};
      default: return 32'b0;
    endcase
  endfunction

  task automatic mdl_reset();
    m_ctrl = '0; m_match = 1'b0; m_count = '0;
    m_cmp = '0; m_pre = '0; m_ph = 0; m_time = edge_n;
  endtask

  task automatic mdl_edge(input bit wr, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int  idx;
    bit  tick;
    bit  hit;
    idx  = wr ? int'(a[11:2]) : -1;
    tick = m_ctrl[0] && (m_ph == int'(m_pre));
    hit  = tick && (m_count == m_cmp) && (idx != 2);
    if (idx == 4) m_ph = 0;
    else if (m_ctrl[0]) m_ph = tick ? 0 : m_ph + 1;
    if (idx == 2) m_count = merge(m_count, d, s);
    else if (tick)
      m_count = (m_count == m_cmp && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    if (idx == 1 && s[0] && d[0]) m_match = 1'b0;
    if (hit) m_match = 1'b1;
    if (idx == 0 && s[0]) m_ctrl = d[2:0];
    if (idx == 3) m_cmp = merge(m_cmp, d, s);
    if (idx == 4) begin
      if (s[0]) m_pre[7:0] = d[7:0];
      if (s[1]) m_pre[15:8] = d[15:8];
    end
    m_time++;
  endtask

  task automatic mdl_to(input int t);
    while (m_time < t) mdl_edge(1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int ce);
    int   n;
    logic aw_ok;
    logic w_ok;
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    s_bready = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 16) begin
      aw_ok = s_awvalid && s_awready;
      w_ok  = s_wvalid && s_wready;
      @(posedge clk); #1;
      n++;
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok) s_wvalid = 1'b0;
    end
    chk("wr_handshake", {31'b0, s_awvalid | s_wvalid}, 32'd0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    ce = edge_n;
    mdl_to(ce - 1);
    mdl_edge(1'b1, a, d, s);
    chk("wr_bvalid", {31'b0, s_bvalid}, 32'd1);
    chk("wr_bresp", {30'b0, s_bresp}, off_ok(a) ? 32'd0 : 32'd2);
    @(posedge clk); #1;
    chk("wr_bdone", {31'b0, s_bvalid}, 32'd0);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d);
    int          n;
    logic [31:0] exp;
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    mdl_to(edge_n);
    exp = mdl_read(a);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    chk("rd_rvalid", {31'b0, s_rvalid}, 32'd1);
    chk("rd_rdata", s_rdata, exp);
    chk("rd_rresp", {30'b0, s_rresp}, off_ok(a) ? 32'd0 : 32'd2);
    d = s_rdata;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic chk_irq(input string tag);
    mdl_to(edge_n);
    chk(tag, {31'b0, irq}, {31'b0, m_match & m_ctrl[2]});
  endtask

  initial begin
    logic [31:0] d;
    int          e0;
    int          ce;
    int          offs[8];
    int          sel;
    logic [11:0] a;
    logic [3:0]  s;

    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_reset();

    chk("rst_awready", {31'b0, s_awready}, 32'd1);
    chk("rst_wready", {31'b0, s_wready}, 32'd1);
    chk("rst_arready", {31'b0, s_arready}, 32'd1);
    chk("rst_bvalid", {31'b0, s_bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, s_rvalid}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    do_read(12'h008, d);
    chk("rst_count", d, 32'd0);

    // Match and auto-reload
    do_write(12'h010, 32'd0, 4'hF, ce);
    do_write(12'h00C, 32'd5, 4'hF, ce);
    do_write(12'h000, 32'd7, 4'hF, e0);
    for (int k = 1; k <= 8; k++) begin
      while (edge_n < e0 + k) begin
        @(posedge clk); #1;
      end
      chk("irq_rise", {31'b0, irq}, (k >= 6) ? 32'd1 : 32'd0);
    end
    do_read(12'h004, d);
    chk("match_set", d, 32'd1);
    do_read(12'h008, d);
    do_read(12'h008, d);
    do_write(12'h000, 32'd6, 4'hF, ce);
    chk_irq("irq_hold");
    do_write(12'h004, 32'd1, 4'h1, ce);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    do_read(12'h004, d);

    // AW three cycles ahead of W, B held off four cycles
    s_awaddr = 12'h00C; s_awvalid = 1'b1; s_bready = 1'b0;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    chk("skew_aw_busy", {31'b0, s_awready}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("skew_no_b", {31'b0, s_bvalid}, 32'd0);
    end
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    chk("skew_wready", {31'b0, s_wready}, 32'd1);
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    ce = edge_n;
    mdl_to(ce - 1);
    mdl_edge(1'b1, 12'h00C, 32'h1234_5678, 4'hF);
    repeat (4) begin
      chk("skew_bvalid", {31'b0, s_bvalid}, 32'd1);
      chk("skew_bresp", {30'b0, s_bresp}, 32'd0);
      chk("skew_rdy", {30'b0, s_awready, s_wready}, 32'd0);
      @(posedge clk); #1;
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    chk("skew_bdone", {31'b0, s_bvalid}, 32'd0);
    chk("skew_awfree", {31'b0, s_awready}, 32'd1);
    s_bready = 1'b0;
    do_read(12'h00C, d);
    chk("skew_cmp", d, 32'h1234_5678);

    // Decode error
    do_write(12'h020, 32'hFFFF_FFFF, 4'hF, ce);
    for (int i = 0; i < 5; i++) do_read(12'(4 * i), d);
    do_read(12'h020, d);
    chk("derr_rdata", d, 32'd0);

    // Byte strobes on COUNT with the timer stopped
    do_write(12'h008, 32'd0, 4'hF, ce);
    do_write(12'h008, 32'hAABB_CCDD, 4'b0011, ce);
    do_read(12'h008, d);
    chk("strb_count", d, 32'h0000_CCDD);

    // W1C landing on the match edge
    do_write(12'h00C, 32'd10, 4'hF, ce);
    do_write(12'h008, 32'd0, 4'hF, ce);
    do_write(12'h000, 32'd5, 4'hF, e0);
    while (edge_n < e0 + 10) begin
      @(posedge clk); #1;
    end
    do_write(12'h004, 32'd1, 4'h1, ce);
    chk("w1c_edge", ce, e0 + 11);
    chk("w1c_irq", {31'b0, irq}, 32'd1);
    do_read(12'h004, d);
    chk("w1c_keep", d, 32'd1);

    // Reset pulsed between AW and W
    s_awaddr = 12'h00C; s_awvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstmid_bvalid", {31'b0, s_bvalid}, 32'd0);
    chk("rstmid_awready", {31'b0, s_awready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk("rstmid_no_b", {31'b0, s_bvalid}, 32'd0);
    end
    do_write(12'h008, 32'h55, 4'hF, ce);
    do_read(12'h008, d);
    chk("rstmid_count", d, 32'h55);
    do_read(12'h00C, d);
    chk_irq("rstmid_irq");

    // Randomized register traffic against the model
    offs = '{0, 4, 8, 12, 16, 32, 20, 12'hFFC};
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 7));
      a = 12'(offs[sel]) | 12'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      if (sel == 2 || sel == 3) begin
        if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 12));
        if ($urandom_range(0, 1) == 0) s = 4'hF;
      end
      if (sel == 4) d[15:0] = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) do_write(a, d, s, ce);
      else do_read(a, d);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      chk_irq("rand_irq");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
